// File: rtl/clksw_requester.sv
// clksw_requester
//   Initiator side of the CPU clock-switch handshake. Converts a per-cycle
//   "fast clock wanted" request into a stable hsclk_sel level. It holds the
//   CPU while a switch is pending. It waits out a hysteresis period before
//   dropping back to the slow clock. It flags switches that never complete.
//   Everything runs on the free-running reference clock clk_in.
//
// Ports
//   clk_in          free-running reference clock, rising edge
//   rst             synchronous active-high reset
//   en              1 = fast switching permitted, 0 = force/hold slow clock
//   hs_req          decoder wants the fast clock this cycle
//   hsclk_selected  switch status (asynchronous to clk_in)
//   lsclk_selected  switch status (asynchronous to clk_in)
//   hsclk_sel       registered request level to the clock switch
//   stall           hold the CPU while a switch is pending (combinational)
//   hs_active       registered, 1 only in HS_RUN
//   timeout_err     sticky transition-timeout flag, cleared only by rst
//   state_o         00 LS_RUN, 01 TO_HS, 10 HS_RUN, 11 TO_LS

module clksw_requester #(
  parameter int SYNC_STAGES = 2,   // >= 2
  parameter int HOLD_CYCLES = 16,  // 1..255
  parameter int TIMEOUT     = 255  // 1..255
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic       hs_req,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic       stall,
  output logic       hs_active,
  output logic       timeout_err,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    LS_RUN = 2'b00,
    TO_HS  = 2'b01,
    HS_RUN = 2'b10,
    TO_LS  = 2'b11
  } state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [7:0]             tcount_q, tcount_d;  // cycles spent in a transition state
  logic [7:0]             dcount_q, dcount_d;  // consecutive idle cycles in HS_RUN
  logic                   err_set;
  logic [SYNC_STAGES-1:0] hs_chain, ls_chain;
  logic                   hs_sync, ls_sync;

  // Status synchronisers. The chains are cleared on reset so that no stale
  // status sampled before reset can complete a handshake afterwards.
  always_ff @(posedge clk_in) begin
    // NOTE: clocked blocks use non-blocking assignments only, so every flop
    // samples the pre-edge value of the flop ahead of it in the chain.
    if (rst) begin
      hs_chain <= '0;
      ls_chain <= '0;
    end else begin
      hs_chain <= {hs_chain[SYNC_STAGES-2:0], hsclk_selected};
      ls_chain <= {ls_chain[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  assign hs_sync = hs_chain[SYNC_STAGES-1];
  assign ls_sync = ls_chain[SYNC_STAGES-1];

  // State register plus registered outputs. hsclk_sel and hs_active decode
  // the next state, so each output is a clean flop that is constant within
  // a state and changes only on a transition.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= LS_RUN;
      tcount_q    <= '0;
      dcount_q    <= '0;
      hsclk_sel   <= 1'b0;
      hs_active   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcount_q    <= tcount_d;
      dcount_q    <= dcount_d;
      hsclk_sel   <= (state_d == TO_HS) || (state_d == HS_RUN);
      hs_active   <= (state_d == HS_RUN);
      timeout_err <= timeout_err | err_set;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    tcount_d = tcount_q;
    dcount_d = dcount_q;
    err_set  = 1'b0;

    case (state_q)
      LS_RUN: begin
        if (en && hs_req) begin
          state_d  = TO_HS;
          tcount_d = '0;
        end
      end

      TO_HS: begin
        // Losing en aborts the switch even if it completes this cycle.
        if (!en) begin
          state_d  = TO_LS;
          tcount_d = '0;
        end else if (hs_sync && !ls_sync) begin
          state_d  = HS_RUN;
          dcount_d = '0;
        end else if (tcount_q == TMO_LAST) begin
          err_set  = 1'b1;
          state_d  = TO_LS;
          tcount_d = '0;
        end else begin
          tcount_d = tcount_q + 8'd1;
        end
      end

      HS_RUN: begin
        if (!en) begin
          state_d  = TO_LS;
          tcount_d = '0;
        end else if (hs_req) begin
          dcount_d = '0;
        end else if (dcount_q == HOLD_LAST) begin
          state_d  = TO_LS;
          tcount_d = '0;
        end else if (dcount_q != 8'hFF) begin
          dcount_d = dcount_q + 8'd1;
        end
      end

      TO_LS: begin
        // There is no escape from TO_LS except the slow status: the CPU
        // must not run on a clock the switch may still be changing.
        if (ls_sync && !hs_sync) begin
          state_d = LS_RUN;
        end else if (tcount_q == TMO_LAST) begin
          err_set = 1'b1;
        end else begin
          tcount_d = tcount_q + 8'd1;
        end
      end

      default: state_d = LS_RUN;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    stall   = 1'b0;
    state_o = state_q;
    if (!rst) begin
      stall = (state_q == TO_HS) || (state_q == TO_LS) ||
              ((state_q == LS_RUN) && en && hs_req);
    end
  end

endmodule

// File: doc/clksw_requester.md
Name: clksw_requester

Overview:
- Initiator side of the CPU clock-switch handshake.
- Turns a per-cycle "fast clock wanted" request from the address decode into a stable hsclk_sel level for the clock switch.
- Waits for the switch's hsclk_selected/lsclk_selected status before releasing the CPU, applies hysteresis before dropping back to the slow clock, and flags switches that never complete.
- Runs on one free-running reference clock, independent of the switched CPU clock.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising each status input into clk_in (minimum 2).
- HOLD_CYCLES, 16, consecutive cycles hs_req must stay low in HS_RUN before returning to slow clock (1..255).
- TIMEOUT, 255, cycles allowed in a transition state before timeout_err is set (1..255).

Ports:
- clk_in  input  1  free-running reference clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  1 = fast switching permitted; 0 = force and hold slow clock.
- hs_req  input  1  decoder wants fast clock this cycle.
- hsclk_selected  input  1  switch status, asynchronous to clk_in.
- lsclk_selected  input  1  switch status, asynchronous to clk_in.
- hsclk_sel  output  1  registered request level to the clock switch.
- stall  output  1  hold CPU (RDY low) while a switch is pending.
- hs_active  output  1  registered; 1 only in HS_RUN.
- timeout_err  output  1  sticky; set on any transition timeout.
- state_o  output  2  current state: 00 LS_RUN, 01 TO_HS, 10 HS_RUN, 11 TO_LS.

Behaviour:
- Synchronisation and reset:
  - hs_sync / ls_sync are SYNC_STAGES-deep flop chains of hsclk_selected / lsclk_selected; all decisions use the synced values only.
  - Reset (synchronous, rst=1 at a rising edge) sets: state LS_RUN, hsclk_sel=0, hs_active=0, timeout_err=0, counters 0, sync chains 0.
  - Reset mid-transition aborts immediately to LS_RUN with hsclk_sel=0 on the next edge; no handshake completion is awaited.
- stall is combinational: 1 in TO_HS or TO_LS, and in LS_RUN when en & hs_req. 0 in HS_RUN, and 0 during reset.
- LS_RUN:
  - Entry condition to leave: en & hs_req, which gives next state TO_HS, hsclk_sel<=1, tcount<=0.
  - Otherwise stays in LS_RUN with hsclk_sel=0.
- TO_HS:
  - hs_sync=1 & ls_sync=0 gives next state HS_RUN, hs_active<=1, dcount<=0.
  - en=0 gives next state TO_LS, hsclk_sel<=0, tcount<=0. This is the abort, and takes priority over completion in the same cycle.
  - tcount==TIMEOUT-1 without completion: timeout_err<=1, next state TO_LS, hsclk_sel<=0, tcount<=0.
  - Otherwise tcount increments.
- HS_RUN:
  - en=0 gives next state TO_LS immediately; hsclk_sel<=0, hs_active<=0, tcount<=0.
  - hs_req=1 sets dcount<=0.
  - hs_req=0 increments dcount. When dcount==HOLD_CYCLES-1 the next state is TO_LS, with hsclk_sel<=0, hs_active<=0, tcount<=0.
  - dcount is 8 bits and saturates; it never wraps.
- TO_LS:
  - ls_sync=1 & hs_sync=0 gives next state LS_RUN.
  - tcount==TIMEOUT-1: timeout_err<=1. State remains TO_LS with stall held and hsclk_sel=0 until the slow status arrives; tcount saturates at TIMEOUT-1.
  - hs_req is ignored in TO_LS. Re-entry to TO_HS happens only from LS_RUN.
- Latency:
  - hs_req to hsclk_sel = 1 cycle.
  - Switch status change to state change = SYNC_STAGES+1 cycles.
- timeout_err clears only on rst.
- hsclk_sel never toggles except on a state transition; it is constant within each state.

Test Plan:
- Reset and idle: rst for 3 cycles, then en=1, hs_req=0 for 20 cycles -> state_o=00, hsclk_sel=0, stall=0, timeout_err=0 throughout.
- Up-switch: hs_req=1 at cycle 0, model raises hsclk_selected and drops lsclk_selected at cycle 5 -> hsclk_sel=1 from cycle 1, stall=1 through cycle 7, state_o=10 and hs_active=1 at cycle 8 (SYNC_STAGES=2), stall=0 after.
- Hysteresis: in HS_RUN, drop hs_req for 10 cycles, pulse it for 1, then keep it low -> no exit after the first 10 cycles. hsclk_sel falls exactly 16 cycles after the final hs_req low begins, and state_o=11.
- Down-switch completion: after the previous test, model returns lsclk_selected=1, hsclk_selected=0 -> state_o=00 SYNC_STAGES+1 cycles later. hs_req=1 asserted during TO_LS is ignored until LS_RUN.
- Timeout: hs_req=1, switch model never responds -> at cycle 1+255 timeout_err=1, hsclk_sel=0, state_o=11. Model then asserts lsclk_selected -> LS_RUN, and timeout_err stays 1 until rst.
- Abort and reset: en=0 while in TO_HS -> TO_LS next cycle, hsclk_sel=0. Separately, rst asserted mid-TO_HS -> LS_RUN, all outputs at reset values on the next edge.
